elixirchip_es1_spu_op_sel_cmp: RTL and testbench
================================================

# elixirchip_es1_spu_op_sel_cmp

Pipelined compare-and-select primitive for the ES1 SPU datapath, and the generalised successor to the less-than select op. It consumes the flag outputs (carry, carry-into-MSB, sign, zero) of an upstream subtractor that computed `data0 - data1`. It evaluates one of ten signed/unsigned/equality conditions, chosen per transaction or fixed by parameter, and registers `data0` when the condition holds and `data1` otherwise. It adds a configurable pipeline depth, a condition-result output and an output valid, with the same clear/valid/cke semantics as the existing select ops.

## Interface
- `LATENCY`, 1: cke-enabled clocks from input to `m_data`; legal range 1..8, otherwise elaboration error.
- `DATA_BITS`, 8: data width.
- `data_t`, `logic [DATA_BITS-1:0]`: data type.
- `CLEAR_DATA`, `'1`: value loaded into `m_data` on clear and at reset.
- `FIXED_COND`, -1: -1 uses `s_cond` at run time; 0..11 hard-wires the condition and ignores `s_cond`.
- `IMMEDIATE_DATA0` / `IMMEDIATE_DATA1`, 0: the operand is a constant; optimisation hint only, no behavioural effect.
- `DEVICE` "RTL", `SIMULATION` "false", `DEBUG` "false": standard.

Ports:
- `reset`  in  1  asynchronous, active-low reset.
- `clk`  in  1  clock.
- `cke`  in  1  clock enable; all state holds when 0.
- `s_cond`  in  4  condition code (see Operation).
- `s_carry`  in  1  subtract carry-out (1 = no borrow).
- `s_msb_c`  in  1  carry into MSB.
- `s_sign`  in  1  result MSB.
- `s_zero`  in  1  result == 0.
- `s_data0`, `s_data1`  in  DATA_BITS  candidates.
- `s_clear`  in  1  force `CLEAR_DATA`.
- `s_valid`  in  1  transaction valid.
- `m_data`  out  DATA_BITS  selected data.
- `m_flag`  out  1  condition result of last accepted transaction.
- `m_valid`  out  1  `m_data` updated this cycle.

## Operation
- Derived flags: V = `s_carry` ^ `s_msb_c`; LT_S = `s_sign` ^ V; LT_U = !`s_carry`.
- Condition codes:
  - 0 EQ = Z; 1 NE = !Z.
  - 2 LTU = LT_U; 3 GEU = !LT_U; 4 LEU = LT_U | Z; 5 GTU = !(LT_U | Z).
  - 6 LT = LT_S; 7 GE = !LT_S; 8 LE = LT_S | Z; 9 GT = !(LT_S | Z).
  - 10 ALWAYS = 1; 11 NEVER = 0; 12..15 behave as NEVER.
- Stage 1 (`cke`=1) registers: `sel = cond ? s_data0 : s_data1`, `flag = cond`, `valid = s_valid`, `clear = s_clear & s_valid`.
- Stages 2..LATENCY are a plain delay line of {sel, flag, valid, clear}, advancing only on `cke`.
- Output stage, on `cke` with stage valid = 1:
  - clear = 1: `m_data` = `CLEAR_DATA`, `m_flag` = 0.
  - clear = 0: `m_data` = sel, `m_flag` = flag.
- Stage valid = 0: `m_data` and `m_flag` hold their previous values.
- `m_valid` = final-stage valid, registered; it holds while `cke` = 0.
- `s_clear` with `s_valid` = 0 is ignored.
- Clear overrides the condition result.
- Flag inputs are trusted; no consistency check between `s_zero` and the other flags.

## Timing
- Reset (`reset` = 0, asynchronous assert, synchronous-to-`clk` deassert by the system):
  - `m_data` = `CLEAR_DATA`, `m_flag` = 0, `m_valid` = 0.
  - All stage valid and clear bits = 0; stage data is don't-care.
- Reset asserted mid-pipeline drops all in-flight transactions; the first output after release comes from a transaction accepted after release.
- Latency is exactly LATENCY `cke`=1 edges; `cke`=0 cycles stretch it without loss or duplication.
- Throughput is one transaction per `cke` cycle; there is no back-pressure.
- Back-to-back valid transactions update `m_data` on consecutive `cke` cycles.
- `s_cond` is sampled with its data, so changing the condition every cycle is legal.

## Test plan
- LATENCY=1, DATA_BITS=8: cond LTU, data0 = 0x05, data1 = 0x80, flags carry=0, msb_c=1, sign=1, zero=0 -> `m_data` = 0x05, `m_flag` = 1. Same input with cond LT -> `m_data` = 0x80, `m_flag` = 0.
- cond EQ vs LE with data0 = data1 = 0x3C (carry=1, msb_c=1, sign=0, zero=1) -> both select 0x3C with `m_flag` = 1; GT selects data1 with `m_flag` = 0; cond 13 -> NEVER.
- `s_clear`=1, `s_valid`=1 on an ALWAYS transaction -> `m_data` = 0xFF, `m_flag` = 0. `s_clear`=1, `s_valid`=0 -> output unchanged, `m_valid` = 0.
- LATENCY=4, random 10% `cke` drops, random cond/data, 10k transactions -> scoreboard model matches every `m_valid` beat and the held values in between.
- Assert `reset` low asynchronously while 3 transactions are in flight (LATENCY=4) -> outputs go to reset values immediately, no stale beat appears after release.
- FIXED_COND=6 with `s_cond` driven randomly -> results always follow the LT rule.

Source files
------------

// File: rtl/elixirchip_es1_spu_op_sel_cmp.sv
// Pipelined compare-and-select: evaluates a signed/unsigned/equality condition from
// subtractor flags (data0 - data1) and registers data0 when it holds, data1 otherwise.
module elixirchip_es1_spu_op_sel_cmp #(
  parameter int    LATENCY         = 1,
  parameter int    DATA_BITS       = 8,
  parameter type   data_t          = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA      = '1,
  parameter int    FIXED_COND      = -1,
  parameter int    IMMEDIATE_DATA0 = 0,
  parameter int    IMMEDIATE_DATA1 = 0,
  parameter string DEVICE          = "RTL",
  parameter string SIMULATION      = "false",
  parameter string DEBUG           = "false"
) (
  input  logic       reset,
  input  logic       clk,
  input  logic       cke,
  input  logic [3:0] s_cond,
  input  logic       s_carry,
  input  logic       s_msb_c,
  input  logic       s_sign,
  input  logic       s_zero,
  input  data_t      s_data0,
  input  data_t      s_data1,
  input  logic       s_clear,
  input  logic       s_valid,
  output data_t      m_data,
  output logic       m_flag,
  output logic       m_valid
);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("LATENCY must be within 1..8");
  end
  if (FIXED_COND < -1 || FIXED_COND > 11) begin : g_bad_cond
    $error("FIXED_COND must be -1 or within 0..11");
  end
  if (IMMEDIATE_DATA0 < 0 || IMMEDIATE_DATA0 > 1 ||
      IMMEDIATE_DATA1 < 0 || IMMEDIATE_DATA1 > 1) begin : g_bad_imm
    $error("IMMEDIATE_DATA0/1 must be 0 or 1");
  end
  if (DEVICE == "" || (SIMULATION != "false" && SIMULATION != "true") ||
      (DEBUG != "false" && DEBUG != "true")) begin : g_bad_str
    $error("DEVICE must be non-empty; SIMULATION/DEBUG must be \"true\" or \"false\"");
  end

  localparam bit         COND_IS_FIXED = (FIXED_COND >= 0);
  localparam logic [3:0] FIXED_CODE    = 4'((FIXED_COND < 0) ? 0 : FIXED_COND);

  typedef enum logic [3:0] {
    COND_EQ     = 4'd0,
    COND_NE     = 4'd1,
    COND_LTU    = 4'd2,
    COND_GEU    = 4'd3,
    COND_LEU    = 4'd4,
    COND_GTU    = 4'd5,
    COND_LT     = 4'd6,
    COND_GE     = 4'd7,
    COND_LE     = 4'd8,
    COND_GT     = 4'd9,
    COND_ALWAYS = 4'd10,
    COND_NEVER  = 4'd11
  } cond_e;

  logic [3:0] cond_code;
  logic       ovf;
  logic       lt_s;
  logic       lt_u;
  logic       cond_hit;

  assign cond_code = COND_IS_FIXED ? FIXED_CODE : s_cond;
  assign ovf       = s_carry ^ s_msb_c;
  assign lt_s      = s_sign ^ ovf;
  assign lt_u      = ~s_carry;

  // Codes 12..15 fall into the default and behave as NEVER.
  always_comb begin
    cond_hit = 1'b0;
    case (cond_code)
      COND_EQ:     cond_hit = s_zero;
      COND_NE:     cond_hit = ~s_zero;
      COND_LTU:    cond_hit = lt_u;
      COND_GEU:    cond_hit = ~lt_u;
      COND_LEU:    cond_hit = lt_u | s_zero;
      COND_GTU:    cond_hit = ~(lt_u | s_zero);
      COND_LT:     cond_hit = lt_s;
      COND_GE:     cond_hit = ~lt_s;
      COND_LE:     cond_hit = lt_s | s_zero;
      COND_GT:     cond_hit = ~(lt_s | s_zero);
      COND_ALWAYS: cond_hit = 1'b1;
      default:     cond_hit = 1'b0;
    endcase
  end

  data_t head_sel;
  logic  head_flag;
  logic  head_valid;
  logic  head_clear;

  assign head_sel   = cond_hit ? s_data0 : s_data1;
  assign head_flag  = cond_hit;
  assign head_valid = s_valid;
  assign head_clear = s_clear & s_valid;

  data_t tail_sel;
  logic  tail_flag;
  logic  tail_valid;
  logic  tail_clear;

  // The output register is the last pipeline stage, so only LATENCY-1 delay stages sit in front.
  if (LATENCY > 1) begin : g_delay
    localparam int DEPTH = LATENCY - 1;

    data_t sel_q   [DEPTH];
    logic  flag_q  [DEPTH];
    logic  valid_q [DEPTH];
    logic  clear_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          sel_q[i]   <= '0;
          flag_q[i]  <= 1'b0;
          valid_q[i] <= 1'b0;
          clear_q[i] <= 1'b0;
        end
      end else if (cke) begin
        sel_q[0]   <= head_sel;
        flag_q[0]  <= head_flag;
        valid_q[0] <= head_valid;
        clear_q[0] <= head_clear;
        for (int i = 1; i < DEPTH; i++) begin
          sel_q[i]   <= sel_q[i-1];
          flag_q[i]  <= flag_q[i-1];
          valid_q[i] <= valid_q[i-1];
          clear_q[i] <= clear_q[i-1];
        end
      end
    end

    assign tail_sel   = sel_q[DEPTH-1];
    assign tail_flag  = flag_q[DEPTH-1];
    assign tail_valid = valid_q[DEPTH-1];
    assign tail_clear = clear_q[DEPTH-1];
  end else begin : g_direct
    assign tail_sel   = head_sel;
    assign tail_flag  = head_flag;
    assign tail_valid = head_valid;
    assign tail_clear = head_clear;
  end

  data_t m_data_q;
  data_t m_data_d;
  logic  m_flag_q;
  logic  m_flag_d;
  logic  m_valid_q;
  logic  m_valid_d;

  always_comb begin
    m_data_d  = m_data_q;
    m_flag_d  = m_flag_q;
    m_valid_d = tail_valid;
    if (tail_valid) begin
      if (tail_clear) begin
        m_data_d = CLEAR_DATA;
        m_flag_d = 1'b0;
      end else begin
        m_data_d = tail_sel;
        m_flag_d = tail_flag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data_q  <= CLEAR_DATA;
      m_flag_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else if (cke) begin
      m_data_q  <= m_data_d;
      m_flag_q  <= m_flag_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_flag  = m_flag_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_sel_cmp.sv
// Directed bench: LATENCY=1, LATENCY=4 and FIXED_COND=6 instances share one input stream.
module tb_elixirchip_es1_spu_op_sel_cmp;

  logic       clk = 1'b0;
  logic       reset;
  logic       cke;
  logic [3:0] s_cond;
  logic       s_carry, s_msb_c, s_sign, s_zero;
  logic [7:0] s_data0, s_data1;
  logic       s_clear, s_valid;

  logic [7:0] m_data1, m_data4, m_dataf;
  logic       m_flag1, m_flag4, m_flagf;
  logic       m_valid1, m_valid4, m_validf;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_sel_cmp #(.LATENCY(1), .DATA_BITS(8)) dut1 (
    .reset(reset), .clk(clk), .cke(cke), .s_cond(s_cond), .s_carry(s_carry),
    .s_msb_c(s_msb_c), .s_sign(s_sign), .s_zero(s_zero), .s_data0(s_data0),
    .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
    .m_data(m_data1), .m_flag(m_flag1), .m_valid(m_valid1)
  );

  elixirchip_es1_spu_op_sel_cmp #(.LATENCY(4), .DATA_BITS(8)) dut4 (
    .reset(reset), .clk(clk), .cke(cke), .s_cond(s_cond), .s_carry(s_carry),
    .s_msb_c(s_msb_c), .s_sign(s_sign), .s_zero(s_zero), .s_data0(s_data0),
    .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
    .m_data(m_data4), .m_flag(m_flag4), .m_valid(m_valid4)
  );

  elixirchip_es1_spu_op_sel_cmp #(.LATENCY(1), .DATA_BITS(8), .FIXED_COND(6)) dutf (
    .reset(reset), .clk(clk), .cke(cke), .s_cond(s_cond), .s_carry(s_carry),
    .s_msb_c(s_msb_c), .s_sign(s_sign), .s_zero(s_zero), .s_data0(s_data0),
    .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
    .m_data(m_dataf), .m_flag(m_flagf), .m_valid(m_validf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_clear = 1'b0;
    s_cond  = 4'($urandom_range(0, 15));
  endtask

  // flags = {carry, msb_c, sign, zero}
  task automatic drive(input logic [3:0] cond, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [3:0] flags, input logic clr, input logic vld);
    s_cond  = cond;
    s_data0 = d0;
    s_data1 = d1;
    {s_carry, s_msb_c, s_sign, s_zero} = flags;
    s_clear = clr;
    s_valid = vld;
  endtask

  task automatic chk1(input string tag, input logic [7:0] d, input logic f, input logic v);
    check({tag, ".l1.data"},  32'(m_data1),  32'(d));
    check({tag, ".l1.flag"},  32'(m_flag1),  32'(f));
    check({tag, ".l1.valid"}, 32'(m_valid1), 32'(v));
  endtask

  task automatic chk4(input string tag, input logic [7:0] d, input logic f, input logic v);
    check({tag, ".l4.data"},  32'(m_data4),  32'(d));
    check({tag, ".l4.flag"},  32'(m_flag4),  32'(f));
    check({tag, ".l4.valid"}, 32'(m_valid4), 32'(v));
  endtask

  task automatic chkf(input string tag, input logic [7:0] d, input logic f);
    check({tag, ".fx.data"}, 32'(m_dataf), 32'(d));
    check({tag, ".fx.flag"}, 32'(m_flagf), 32'(f));
  endtask

  // One LATENCY=1 transaction: expected result for dut1 and for the LT-hardwired dutf.
  task automatic vec(input string tag, input logic [3:0] cond, input logic [7:0] d0,
                     input logic [7:0] d1, input logic [3:0] flags, input logic clr,
                     input logic vld, input logic [7:0] e_d, input logic e_f, input logic e_v,
                     input logic [7:0] ef_d, input logic ef_f);
    drive(cond, d0, d1, flags, clr, vld);
    tick();
    chk1(tag, e_d, e_f, e_v);
    chkf(tag, ef_d, ef_f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    cke   = 1'b1;
    drive(4'd0, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    chk1("reset", 8'hFF, 1'b0, 1'b0);
    chk4("reset", 8'hFF, 1'b0, 1'b0);
    chkf("reset", 8'hFF, 1'b0);
    check("reset.fx.valid", 32'(m_validf), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Borrow with overflow: LT_U=1, LT_S=0.
    vec("ltu", 4'd2, 8'h05, 8'h80, 4'b0110, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 8'h80, 1'b0);
    vec("lt",  4'd6, 8'h05, 8'h80, 4'b0110, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0);
    // Zero result: Z=1, LT_U=0, LT_S=0.
    vec("eq",    4'd0,  8'h3C, 8'hC3, 4'b1101, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'hC3, 1'b0);
    vec("le",    4'd8,  8'h3C, 8'hC3, 4'b1101, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'hC3, 1'b0);
    vec("gt",    4'd9,  8'h3C, 8'hC3, 4'b1101, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0);
    vec("c13",   4'd13, 8'h3C, 8'hC3, 4'b1101, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0);
    // Borrow, no overflow: LT_U=1, LT_S=0, Z=0.
    vec("ne",    4'd1,  8'hAA, 8'h55, 4'b0000, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 8'h55, 1'b0);
    vec("geu",   4'd3,  8'hAA, 8'h55, 4'b0000, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0);
    vec("leu",   4'd4,  8'hAA, 8'h55, 4'b0000, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 8'h55, 1'b0);
    vec("gtu",   4'd5,  8'hAA, 8'h55, 4'b0000, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0);
    vec("ge",    4'd7,  8'hAA, 8'h55, 4'b0000, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 8'h55, 1'b0);
    // No borrow, overflow: LT_U=0, LT_S=1.
    vec("lt2",   4'd6,  8'hAA, 8'h55, 4'b1000, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 8'hAA, 1'b1);
    vec("ge2",   4'd7,  8'hAA, 8'h55, 4'b1000, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'hAA, 1'b1);
    vec("gtu2",  4'd5,  8'hAA, 8'h55, 4'b1000, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 8'hAA, 1'b1);
    vec("le2",   4'd8,  8'hAA, 8'h55, 4'b1000, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 8'hAA, 1'b1);
    // LT_U=1, LT_S=1, Z=1.
    vec("gt3",   4'd9,  8'hAA, 8'h55, 4'b0011, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'hAA, 1'b1);
    vec("clr",   4'd10, 8'h11, 8'h22, 4'b0000, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0);
    vec("alw",   4'd10, 8'h5A, 8'h00, 4'b0000, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0);
    vec("clrnv", 4'd10, 8'h66, 8'h77, 4'b0000, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0);

    // LATENCY=4 back-to-back.
    idle();
    repeat (5) tick();
    drive(4'd10, 8'h21, 8'h00, 4'b0000, 1'b0, 1'b1);
    tick();
    drive(4'd11, 8'h00, 8'h42, 4'b0000, 1'b0, 1'b1);
    tick();
    drive(4'd10, 8'h33, 8'h00, 4'b0000, 1'b1, 1'b1);
    tick();
    idle();
    chk4("lat4.early", 8'h5A, 1'b1, 1'b0);
    tick();
    chk4("lat4.b1", 8'h21, 1'b1, 1'b1);
    tick();
    chk4("lat4.b2", 8'h42, 1'b0, 1'b1);
    tick();
    chk4("lat4.b3", 8'hFF, 1'b0, 1'b1);
    tick();
    chk4("lat4.idle", 8'hFF, 1'b0, 1'b0);

    // cke=0 stretches latency and holds outputs.
    drive(4'd10, 8'h77, 8'h00, 4'b0000, 1'b0, 1'b1);
    tick();
    idle();
    cke = 1'b0;
    repeat (3) tick();
    chk4("cke.stall", 8'hFF, 1'b0, 1'b0);
    cke = 1'b1;
    repeat (2) tick();
    chk4("cke.3edges", 8'hFF, 1'b0, 1'b0);
    tick();
    chk4("cke.out", 8'h77, 1'b1, 1'b1);
    cke = 1'b0;
    repeat (2) tick();
    chk4("cke.hold", 8'h77, 1'b1, 1'b1);
    cke = 1'b1;
    tick();
    chk4("cke.drop", 8'h77, 1'b1, 1'b0);

    // Asynchronous reset with three transactions in flight.
    drive(4'd10, 8'h01, 8'h00, 4'b0000, 1'b0, 1'b1);
    tick();
    drive(4'd10, 8'h02, 8'h00, 4'b0000, 1'b0, 1'b1);
    tick();
    drive(4'd10, 8'h03, 8'h00, 4'b0000, 1'b0, 1'b1);
    tick();
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk4("arst", 8'hFF, 1'b0, 1'b0);
    chk1("arst", 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk4("arst.nostale", 8'hFF, 1'b0, 1'b0);
    end
    drive(4'd10, 8'h09, 8'h00, 4'b0000, 1'b0, 1'b1);
    tick();
    idle();
    repeat (3) tick();
    chk4("arst.first", 8'h09, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
